// File: rtl/morse_encoder_if.sv
// morse_encoder_if -- read handshake between the UART receive FIFO and the
// Morse encoder.
//   fifo_empty_i : FIFO empty flag (FIFO -> encoder)
//   fifo_data_i  : FIFO read data, valid the cycle after a pop (FIFO -> encoder)
//   fifo_rd_o    : one-cycle pop strobe (encoder -> FIFO)
// master = the encoder (issues pops), slave = the FIFO.
interface morse_encoder_if;
  logic       fifo_empty_i;
  logic [7:0] fifo_data_i;
  logic       fifo_rd_o;

  modport master (input fifo_empty_i, input fifo_data_i, output fifo_rd_o);
  modport slave  (output fifo_empty_i, output fifo_data_i, input fifo_rd_o);
endinterface

// File: rtl/morse_encoder.sv
// morse_encoder -- pops bytes from the UART receive FIFO, looks each one up
// in an ITU Morse table and keys morse_o with fixed unit timing.
//   clk_i, reset_i : clock, synchronous active-high reset
//   fifo           : FIFO read handshake (master side)
//   morse_o        : keying output, 1 = tone/LED on
//   busy_o         : high in every state except IDLE
//   char_done_o    : one-cycle pulse on the last cycle of a character's
//                    trailing gap (or of a word gap)
//   invalid_o      : one-cycle pulse in FETCH when the byte has no code
// Timing: dot 1U high, dash 3U high, intra-char gap 1U, char gap 3U,
// space 7U, with U = UNIT_TICKS clocks.
module morse_encoder #(
  parameter int UNIT_TICKS = 10_000_000,
  parameter int CNT_WIDTH  = 24
) (
  input  logic            clk_i,
  input  logic            reset_i,
  morse_encoder_if.master fifo,
  output logic            morse_o,
  output logic            busy_o,
  output logic            char_done_o,
  output logic            invalid_o
);

  typedef enum logic [2:0] {
    IDLE, FETCH, MARK, GAP, CHAR_GAP, WORD_GAP
  } state_e;

  localparam logic [CNT_WIDTH-1:0] TICK_MAX = CNT_WIDTH'(UNIT_TICKS - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] tick_q, tick_d;   // clocks within the current unit
  logic [2:0]           units_q, units_d; // units elapsed in the current state
  logic [4:0]           shift_q, shift_d; // pattern, current symbol in MSB
  logic [2:0]           rem_q, rem_d;     // symbols left, including current
  logic                 morse_q, morse_d;

  logic       unit_end;
  logic [2:0] seg_last;
  logic       seg_done;
  logic       rd_req;
  logic [7:0] code;

  // {length, pattern}; pattern is left-aligned, first symbol in bit 4,
  // 0 = dot, 1 = dash. Length 0 means no code for this byte.
  function automatic logic [7:0] lookup(input logic [7:0] b);
    logic [7:0] u;
    u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
    case (u)
      8'h41: lookup = {3'd2, 5'b01000}; // A .-
      8'h42: lookup = {3'd4, 5'b10000}; // B -...
      8'h43: lookup = {3'd4, 5'b10100}; // C -.-.
      8'h44: lookup = {3'd3, 5'b10000}; // D -..
      8'h45: lookup = {3'd1, 5'b00000}; // E .
      8'h46: lookup = {3'd4, 5'b00100}; // F ..-.
      8'h47: lookup = {3'd3, 5'b11000}; // G --.
      8'h48: lookup = {3'd4, 5'b00000}; // H ....
      8'h49: lookup = {3'd2, 5'b00000}; // I ..
      8'h4A: lookup = {3'd4, 5'b01110}; // J .---
      8'h4B: lookup = {3'd3, 5'b10100}; // K -.-
      8'h4C: lookup = {3'd4, 5'b01000}; // L .-..
      8'h4D: lookup = {3'd2, 5'b11000}; // M --
      8'h4E: lookup = {3'd2, 5'b10000}; // N -.
      8'h4F: lookup = {3'd3, 5'b11100}; // O ---
      8'h50: lookup = {3'd4, 5'b01100}; // P .--.
      8'h51: lookup = {3'd4, 5'b11010}; // Q --.-
      8'h52: lookup = {3'd3, 5'b01000}; // R .-.
      8'h53: lookup = {3'd3, 5'b00000}; // S ...
      8'h54: lookup = {3'd1, 5'b10000}; // T -
      8'h55: lookup = {3'd3, 5'b00100}; // U ..-
      8'h56: lookup = {3'd4, 5'b00010}; // V ...-
      8'h57: lookup = {3'd3, 5'b01100}; // W .--
      8'h58: lookup = {3'd4, 5'b10010}; // X -..-
      8'h59: lookup = {3'd4, 5'b10110}; // Y -.--
      8'h5A: lookup = {3'd4, 5'b11000}; // Z --..
      8'h30: lookup = {3'd5, 5'b11111}; // 0 -----
      8'h31: lookup = {3'd5, 5'b01111}; // 1 .----
      8'h32: lookup = {3'd5, 5'b00111}; // 2 ..---
      8'h33: lookup = {3'd5, 5'b00011}; // 3 ...--
      8'h34: lookup = {3'd5, 5'b00001}; // 4 ....-
      8'h35: lookup = {3'd5, 5'b00000}; // 5 .....
      8'h36: lookup = {3'd5, 5'b10000}; // 6 -....
      8'h37: lookup = {3'd5, 5'b11000}; // 7 --...
      8'h38: lookup = {3'd5, 5'b11100}; // 8 ---..
      8'h39: lookup = {3'd5, 5'b11110}; // 9 ----.
      default: lookup = 8'h00;
    endcase
  endfunction

  assign unit_end = (tick_q == TICK_MAX);
  assign code     = lookup(fifo.fifo_data_i);

  // Index of the final unit for the current state.
  always_comb begin
    seg_last = 3'd0;
    case (state_q)
      MARK:     seg_last = shift_q[4] ? 3'd2 : 3'd0;
      CHAR_GAP: seg_last = 3'd2;
      WORD_GAP: seg_last = 3'd6;
      default:  seg_last = 3'd0;
    endcase
  end

  assign seg_done = unit_end && (units_q == seg_last);

  always_comb begin
    state_d     = state_q;
    tick_d      = unit_end ? '0 : tick_q + 1'b1;
    units_d     = unit_end ? units_q + 3'd1 : units_q;
    shift_d     = shift_q;
    rem_d       = rem_q;
    rd_req      = 1'b0;
    char_done_o = 1'b0;
    invalid_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo.fifo_empty_i) begin
          rd_req  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (fifo.fifo_data_i == 8'h20) begin
          state_d = WORD_GAP;
        end else if (code[7:5] != 3'd0) begin
          shift_d = code[4:0];
          rem_d   = code[7:5];
          state_d = MARK;
        end else begin
          invalid_o = 1'b1;
          state_d   = IDLE;
        end
      end
      MARK: begin
        if (seg_done) begin
          rem_d   = rem_q - 3'd1;
          state_d = (rem_q > 3'd1) ? GAP : CHAR_GAP;
        end
      end
      GAP: begin
        if (seg_done) begin
          shift_d = {shift_q[3:0], 1'b0};
          state_d = MARK;
        end
      end
      CHAR_GAP, WORD_GAP: begin
        if (seg_done) begin
          char_done_o = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state entry restarts both timing counters.
    if (state_d != state_q) begin
      tick_d  = '0;
      units_d = 3'd0;
    end

    // Registered so morse_o is high exactly while the FSM sits in MARK.
    morse_d = (state_d == MARK);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      tick_q  <= '0;
      units_q <= 3'd0;
      shift_q <= 5'd0;
      rem_q   <= 3'd0;
      morse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      units_q <= units_d;
      shift_q <= shift_d;
      rem_q   <= rem_d;
      morse_q <= morse_d;
    end
  end

  // The pop strobe is combinational from IDLE; gating with reset keeps the
  // FIFO untouched while reset is held.
  assign fifo.fifo_rd_o = rd_req && !reset_i;
  assign morse_o        = morse_q;
  assign busy_o         = (state_q != IDLE);

endmodule
